// File: rtl/router_fifo.sv
// Router output FIFO: stores bytes with a header flag, tracks the packet length
// on read and parks data_out at zero between packets.
module router_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 7;

    typedef struct packed {
        logic             hdr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   pkt_cnt;
    logic            lfd_q;
    logic            last_hdr;
    logic            flush;
    logic            rd_fire;
    logic            wr_fire;
    entry_t          rd_entry;

    // Status comes only from the registered pointers.
    assign flush   = reset | soft_reset;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign vld_out = ~empty;

    // A simultaneous read frees the slot, so a write into a full FIFO is accepted then.
    assign rd_fire  = read_enb & ~empty;
    assign wr_fire  = write_enb & (~full | rd_fire);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (wr_fire && !flush) begin
            mem[wr_ptr[AW-1:0]] <= '{hdr: lfd_q, data: data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            lfd_q    <= 1'b0;
            last_hdr <= 1'b0;
            data_out <= '0;
        end else begin
            lfd_q <= lfd_state;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= rd_entry.data;
                last_hdr <= rd_entry.hdr;
                // Header byte carries the payload length in bits [7:2]; +1 covers parity.
                if (rd_entry.hdr) begin
                    pkt_cnt <= CW'(rd_entry.data[7:2]) + CW'(1);
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - CW'(1);
                end
            end else if (pkt_cnt == '0 && !last_hdr) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_router_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             soft_reset;
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             vld_out;
    logic             full;
    logic             empty;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       hdr;
        logic [7:0] d;
    } ent_t;

    ent_t       q[$];
    int         m_cnt;
    bit         m_last_hdr;
    bit         m_lfd_prev;
    logic [7:0] m_dout;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    // Advance the reference by one clock edge using the behavioural rules.
    task automatic model_edge(input bit rst, input bit srst, input bit we, input bit lfd,
                              input bit re, input logic [7:0] d);
        bit   rd;
        bit   wr;
        ent_t e;
        if (rst || srst) begin
            q.delete();
            m_cnt      = 0;
            m_last_hdr = 0;
            m_lfd_prev = 0;
            m_dout     = 8'h00;
            return;
        end
        rd = re && (q.size() > 0);
        wr = we && ((q.size() < DEPTH) || rd);
        if (rd) begin
            e          = q.pop_front();
            m_dout     = e.d;
            m_last_hdr = e.hdr;
            if (e.hdr) m_cnt = int'(e.d[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end else if (m_cnt == 0 && !m_last_hdr) begin
            m_dout = 8'h00;
        end
        if (wr) q.push_back('{hdr: m_lfd_prev, d: d});
        m_lfd_prev = lfd;
    endtask

    task automatic step(input bit rst, input bit srst, input bit we, input bit lfd,
                        input bit re, input logic [7:0] d);
        reset      = rst;
        soft_reset = srst;
        write_enb  = we;
        lfd_state  = lfd;
        read_enb   = re;
        data_in    = d;
        model_edge(rst, srst, we, lfd, re, d);
        @(posedge clock);
        #1;
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("vld_out", 32'(vld_out), 32'(q.size() != 0));
    endtask

    logic [7:0] bytes [DEPTH];
    logic [7:0] par;
    logic [7:0] held;

    initial begin
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
        read_enb = 1'b0; data_in = '0;
        m_cnt = 0; m_last_hdr = 0; m_lfd_prev = 0; m_dout = 8'h00;
        #2;

        // Reset state
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(data_out), 32'h00);

        // One packet: header 0C (length 3), three payload bytes, parity
        par = 8'h0C ^ 8'h11 ^ 8'h22 ^ 8'h33;
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h0C);
        step(0, 0, 1, 0, 0, 8'h11);
        step(0, 0, 1, 0, 0, 8'h22);
        step(0, 0, 1, 0, 0, 8'h33);
        step(0, 0, 1, 0, 0, par);
        chk("pkt_vld", 32'(vld_out), 32'd1);
        step(0, 0, 0, 0, 1, 8'h00); chk("pkt_hdr", 32'(data_out), 32'h0C);
        step(0, 0, 0, 0, 1, 8'h00); chk("pkt_p0", 32'(data_out), 32'h11);
        step(0, 0, 0, 0, 1, 8'h00); chk("pkt_p1", 32'(data_out), 32'h22);
        step(0, 0, 0, 0, 1, 8'h00); chk("pkt_p2", 32'(data_out), 32'h33);
        step(0, 0, 0, 0, 1, 8'h00); chk("pkt_par", 32'(data_out), 32'(par));
        step(0, 0, 0, 0, 0, 8'h00);
        chk("pkt_idle", 32'(data_out), 32'h00);
        chk("pkt_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            bytes[i] = 8'($urandom_range(1, 255));
            step(0, 0, 1, 0, 0, bytes[i]);
        end
        chk("fill_full", 32'(full), 32'd1);
        step(0, 0, 1, 0, 0, 8'hEE);
        chk("ovf_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 1, 8'h00);
            chk("drain_order", 32'(data_out), 32'(bytes[i]));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous read and write while full
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0, 8'(i + 8'h40));
        step(0, 0, 1, 0, 1, 8'hA5);
        chk("rw_full_dout", 32'(data_out), 32'h40);
        chk("rw_full_flag", 32'(full), 32'd1);

        // Read from empty leaves data_out alone
        step(1, 0, 0, 0, 0, 8'h00);
        held = data_out;
        step(0, 0, 0, 0, 1, 8'h00);
        chk("rd_empty_dout", 32'(data_out), 32'(held));
        chk("rd_empty_vld", 32'(vld_out), 32'd0);

        // Soft reset flushes a partially filled FIFO
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 8'(8'h80 + i));
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("srst_empty", 32'(empty), 32'd1);
        chk("srst_dout", 32'(data_out), 32'h00);
        step(0, 0, 1, 0, 0, 8'h5A);
        step(0, 0, 0, 0, 1, 8'h00);
        chk("srst_after", 32'(data_out), 32'h5A);

        // Reset wins over soft_reset, write and read together
        step(0, 0, 1, 0, 0, 8'h77);
        step(1, 1, 1, 1, 1, 8'h99);
        chk("rst_prio_empty", 32'(empty), 32'd1);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Long random run including headers and occasional flushes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 2) != 0), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of storage entries (power of 2).
REQ-002 SHALL have parameter WIDTH, default 8, payload byte width.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on posedge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port soft_reset  input  1  synchronous flush from the router FSM timeout.
REQ-006 SHALL have port write_enb  input  1  write request from the router register stage.
REQ-007 SHALL have port lfd_state  input  1  high while the header byte is being written.
REQ-008 SHALL have port data_in  input  WIDTH  byte to store.
REQ-009 SHALL have port read_enb  input  1  read request from the destination.
REQ-010 SHALL have port data_out  output  WIDTH  registered read data.
REQ-011 SHALL have port vld_out  output  1  FIFO holds at least one entry (equals ~empty).
REQ-012 SHALL have port full  output  1  occupancy equals DEPTH.
REQ-013 SHALL have port empty  output  1  occupancy equals 0.

Function
REQ-014 SHALL store WIDTH+1 bits per entry: data_in plus a header flag equal to lfd_state registered one cycle (lfd_state is high in the cycle before the header byte is written).
REQ-015 SHALL use write/read pointers of log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-016 SHALL write on a posedge with write_enb=1 and full=0; write_enb while full SHALL be ignored, with no pointer or data change.
REQ-017 SHALL read on a posedge with read_enb=1 and empty=0; data_out SHALL update at that edge (1-cycle latency from read_enb sampled).
REQ-018 Read_enb while empty SHALL be ignored; data_out SHALL hold its last value.
REQ-019 Simultaneous read and write SHALL both occur in the same cycle; occupancy unchanged; allowed when full (read frees the slot first) only if read_enb=1 and empty=0; write while full without read SHALL be dropped.
REQ-020 Pointers SHALL wrap modulo 2*DEPTH; wrap-around SHALL not corrupt full/empty.
REQ-021 SHALL keep a 7-bit packet counter: when an entry with header flag=1 is read, load counter = data[7:2] + 1 (payload length plus parity).
REQ-022 Each read of a non-header entry SHALL decrement the counter if nonzero.
REQ-023 When counter is 0 and the last read entry was not a header, data_out SHALL be driven 8'h00 on the next posedge (packet boundary idle value).
REQ-024 vld_out, full, empty SHALL be combinational from registered pointers only (no input-to-output paths).

Reset
REQ-025 On reset=1 at posedge: pointers=0, counter=0, header-flag pipeline=0, data_out=8'h00; hence empty=1, full=0, vld_out=0.
REQ-026 On soft_reset=1 (reset=0) at posedge: same effect as REQ-025; storage contents need not be cleared.
REQ-027 reset SHALL take priority over soft_reset, write_enb and read_enb in the same cycle.
REQ-028 Reset or soft_reset during a packet read SHALL abort it; the next read after reset SHALL see empty=1 until new writes.

Verification
REQ-029 Reset then write header 8'h0C (length 3) with lfd_state, 3 payload bytes, parity -> after 5 writes vld_out=1, empty=0; 5 reads return 0C,p0,p1,p2,parity, then data_out=00, empty=1.
REQ-030 Write 16 bytes with no reads -> full=1 after 16th edge; 17th write_enb ignored; 16 reads return the 16 bytes in order.
REQ-031 With FIFO full, assert write_enb and read_enb together -> oldest byte out, new byte stored, full stays 1.
REQ-032 Read_enb with empty=1 -> pointers unchanged, data_out unchanged, vld_out=0.
REQ-033 Fill 10 entries, assert soft_reset for one cycle -> next edge empty=1, vld_out=0, data_out=00; subsequent write/read works.
REQ-034 Run 40 writes/reads interleaved over pointer wrap -> data order preserved, no spurious full/empty.
